// File: rtl/parity_pkg.sv
// Shared types and constants for the even-parity sequencing controller.
package parity_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic MODE_GEN = 1'b0;
  localparam logic MODE_CHK = 1'b1;

endpackage

// File: rtl/parity_if.sv
// Word-in / result-out valid-ready bundle for parity_seq_ctrl.
interface parity_if #(
  parameter int DATA_W = 8
);

  logic          in_valid;
  logic          in_ready;
  logic [DATA_W:0] in_data;
  logic          mode;
  logic          out_valid;
  logic          out_ready;
  logic [DATA_W:0] out_frame;
  logic          out_err;

  modport master (
    output in_valid,
    output in_data,
    output mode,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_frame,
    input  out_err
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  mode,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_frame,
    output out_err
  );

endinterface

// File: rtl/parity_bit_acc.sv
// Serial XOR accumulator: folds one bit per enabled cycle into parity.
module parity_bit_acc (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  input  logic data_bit,
  output logic parity
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      parity <= 1'b0;
    else if (clear)
      parity <= 1'b0;
    else if (enable)
      parity <= parity ^ data_bit;
  end

endmodule

// File: rtl/parity_seq_ctrl.sv
// Sequencer walking words bit-serially through the parity accumulator
// to generate or check even parity, with a saturating error count.
module parity_seq_ctrl
  import parity_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  parity_if.slave              bus,
  input  logic                 err_clr,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 busy
);

  localparam int CNT_W = $clog2(DATA_W + 2);

  state_t           state;
  state_t           state_nx;
  logic [DATA_W:0]  sh;
  logic [DATA_W:0]  cap;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] last;
  logic             mode_q;
  logic             acc_clr;
  logic             acc_en;
  logic             acc_par;
  logic             in_rdy;
  logic             out_vld;
  logic             in_hs;
  logic             out_hs;
  logic             err;

  // Check mode folds the received parity bit in as well.
  assign last = (mode_q == MODE_CHK) ? CNT_W'(DATA_W)
                                     : CNT_W'(DATA_W - 1);

  assign in_hs  = bus.in_valid && in_rdy;
  assign out_hs = out_vld && bus.out_ready;

  always_comb begin
    state_nx = state;
    in_rdy   = 1'b0;
    out_vld  = 1'b0;
    acc_clr  = 1'b0;
    acc_en   = 1'b0;
    unique case (state)
      IDLE: begin
        in_rdy = 1'b1;
        if (bus.in_valid) begin
          acc_clr  = 1'b1;
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        acc_en = 1'b1;
        if (cnt == last)
          state_nx = DONE;
      end
      DONE: begin
        out_vld = 1'b1;
        if (bus.out_ready)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh     <= '0;
      cap    <= '0;
      cnt    <= '0;
      mode_q <= MODE_GEN;
    end else if (in_hs) begin
      sh     <= bus.in_data;
      cap    <= bus.in_data;
      cnt    <= '0;
      mode_q <= bus.mode;
    end else if (state == SHIFT) begin
      sh  <= sh >> 1;
      cnt <= cnt + 1'b1;
    end
  end

  parity_bit_acc u_acc (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (acc_clr),
    .enable   (acc_en),
    .data_bit (sh[0]),
    .parity   (acc_par)
  );

  // acc and cap are frozen while in DONE, so the result holds under stall.
  assign err = out_vld && (mode_q == MODE_CHK) && acc_par;

  always_comb begin
    bus.out_frame = '0;
    if (out_vld) begin
      if (mode_q == MODE_CHK)
        bus.out_frame = cap;
      else
        bus.out_frame = {acc_par, cap[DATA_W-1:0]};
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = out_vld;
  assign bus.out_err   = err;
  assign busy          = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_count <= '0;
    else if (err_clr)
      err_count <= '0;
    else if (out_hs && err && (err_count != '1))
      err_count <= err_count + 1'b1;
  end

endmodule
